// File: rtl/param_systolic_core.sv
// DIM x DIM weight-stationary systolic matmul core with job controller, input skew,
// output deskew and a 2*DIM-deep result FIFO. Define QUANT_OUT_EN for quantised results.
module param_systolic_core #(
    parameter int WIDTH      = 16,
    parameter int ACCUMULATE = 32,
    parameter int DIM        = 4,
    parameter int MAX_VECS   = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int QSHIFT     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(MAX_VECS+1)-1:0] num_vecs,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [DIM*DIM*WIDTH-1:0]      weights,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [DIM*WIDTH-1:0]          activation,
    output logic                          r_valid,
    input  logic                          r_ready,
`ifdef QUANT_OUT_EN
    output logic [DIM*OUT_WIDTH-1:0]      result,
`else
    output logic [DIM*ACCUMULATE-1:0]     result,
`endif
    output logic                          busy,
    output logic                          done
);

    localparam int NW    = $clog2(MAX_VECS+1);
    localparam int DEPTH = 2*DIM;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int VL    = 2*DIM;
`ifdef QUANT_OUT_EN
    localparam int EW    = OUT_WIDTH;
`else
    localparam int EW    = ACCUMULATE;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    function automatic logic signed [ACCUMULATE-1:0] mac(
        input logic signed [ACCUMULATE-1:0] ps,
        input logic signed [WIDTH-1:0]      a,
        input logic signed [WIDTH-1:0]      w
    );
        logic signed [2*WIDTH-1:0] prod;
        prod = (2*WIDTH)'(a) * (2*WIDTH)'(w);
        return ps + ACCUMULATE'(prod);
    endfunction

    function automatic logic [EW-1:0] quant(input logic signed [ACCUMULATE-1:0] acc);
`ifdef QUANT_OUT_EN
        logic signed [ACCUMULATE-1:0] sh;
        logic signed [ACCUMULATE-1:0] hi;
        logic signed [ACCUMULATE-1:0] lo;
        sh = acc >>> QSHIFT;
        hi = $signed({{(ACCUMULATE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
        lo = ~hi;
        if (sh > hi)
            return hi[EW-1:0];
        else if (sh < lo)
            return lo[EW-1:0];
        else
            return sh[EW-1:0];
`else
        return acc;
`endif
    endfunction

    logic [2:0]                   state_q, state_d;
    logic [NW-1:0]                num_q, num_d;
    logic [NW-1:0]                cnt_q, cnt_d;
    logic signed [WIDTH-1:0]      w_q  [DIM][DIM];
    logic signed [WIDTH-1:0]      sk_q [DIM][DIM];
    logic signed [WIDTH-1:0]      a_q  [DIM][DIM];
    logic signed [ACCUMULATE-1:0] ps_q [DIM][DIM];
    logic signed [ACCUMULATE-1:0] ds_q [DIM][DIM-1];
    logic [VL-1:0]                vld_q;
    logic [DIM*EW-1:0]            mem_q [DEPTH];
    logic [PW-1:0]                wr_q, rd_q;
    logic [CW-1:0]                fcnt_q, fcnt_d;
    logic [CW-1:0]                infl_q, infl_d;

    logic signed [WIDTH-1:0]      a_in    [DIM][DIM];
    logic signed [ACCUMULATE-1:0] ps_in   [DIM][DIM];
    logic signed [ACCUMULATE-1:0] col_out [DIM];
    logic [DIM*EW-1:0]            push_data;
    logic                         a_acc, w_acc, push, pop;
    logic [CW:0]                  credit_sum;

    assign w_ready    = (state_q == S_LOAD_W);
    assign credit_sum = {1'b0, infl_q} + {1'b0, fcnt_q};
    assign a_ready    = (state_q == S_STREAM) && (credit_sum < (CW+1)'(DEPTH));
    assign a_acc      = a_valid && a_ready;
    assign w_acc      = w_valid && w_ready;
    assign push       = vld_q[VL-1];
    assign r_valid    = (fcnt_q != '0);
    assign pop        = r_ready && r_valid;
    assign result     = r_valid ? mem_q[rd_q] : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign fcnt_d     = fcnt_q + CW'(push) - CW'(pop);
    assign infl_d     = infl_q + CW'(a_acc) - CW'(push);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_vecs;
                    cnt_d   = '0;
                    state_d = (num_vecs == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (w_acc) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (a_acc) cnt_d = cnt_q + NW'(1);
                if (cnt_d == num_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Done only once every accepted vector has been pushed and popped.
                if (infl_q == '0 && fcnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Row i enters through sk_q[i][0..i]; partial sums flow down, activations flow right.
    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_pe
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = sk_q[i][i];
            end else begin : g_a_pass
                assign a_in[i][j] = a_q[i][j-1];
            end
            if (i == 0) begin : g_ps_edge
                assign ps_in[i][j] = '0;
            end else begin : g_ps_pass
                assign ps_in[i][j] = ps_q[i-1][j];
            end
        end
    end

    for (genvar j = 0; j < DIM; j++) begin : g_col
        if (j == DIM-1) begin : g_last
            assign col_out[j] = ps_q[DIM-1][j];
        end else begin : g_dly
            assign col_out[j] = ds_q[j][DIM-2-j];
        end
        assign push_data[j*EW +: EW] = quant(col_out[j]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    w_q[i][j]  <= '0;
                    sk_q[i][j] <= '0;
                    a_q[i][j]  <= '0;
                    ps_q[i][j] <= '0;
                end
                for (int k = 0; k < DIM-1; k++) ds_q[i][k] <= '0;
            end
            vld_q <= '0;
        end else begin
            if (w_acc) begin
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++)
                        w_q[i][j] <= weights[(i*DIM+j)*WIDTH +: WIDTH];
            end
            for (int i = 0; i < DIM; i++) begin
                sk_q[i][0] <= a_acc ? activation[i*WIDTH +: WIDTH] : '0;
                for (int k = 1; k < DIM; k++) sk_q[i][k] <= sk_q[i][k-1];
                for (int j = 0; j < DIM; j++) begin
                    a_q[i][j]  <= a_in[i][j];
                    ps_q[i][j] <= mac(ps_in[i][j], a_in[i][j], w_q[i][j]);
                end
            end
            for (int j = 0; j < DIM; j++) begin
                ds_q[j][0] <= ps_q[DIM-1][j];
                for (int k = 1; k < DIM-1; k++) ds_q[j][k] <= ds_q[j][k-1];
            end
            vld_q <= {vld_q[VL-2:0], a_acc};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            infl_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            infl_q  <= infl_d;
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + PW'(1);
            end
            if (pop) rd_q <= (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + PW'(1);
        end
    end

endmodule
